// File: rtl/internal_fifo_word_unpacker.sv
// internal_fifo_word_unpacker
// Drains a show-ahead FIFO read port and replays each wide word as a
// sequence of narrow beats on a valid/ready interface. The pop decision
// comes only from registered holding state plus in_empty/out_ready, so
// in_rdreq stays one AND level away from the consumer's ready.
module internal_fifo_word_unpacker #(
  parameter  int OUT_WIDTH = 8,
  parameter  int RATIO     = 4,
  parameter  int VAR_LEN   = 0,
  parameter  int LSB_FIRST = 1,
  localparam int CW        = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1,
  localparam int PW        = RATIO * OUT_WIDTH,
  localparam int IN_WIDTH  = PW + ((VAR_LEN != 0) ? CW : 0)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_empty,
  input  logic [IN_WIDTH-1:0]  in_q,
  output logic                 in_rdreq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 error_out
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } StateT;

  localparam logic [CW-1:0] MaxIdx = CW'(RATIO - 1);

  StateT         r_state;
  StateT         w_nextState;
  logic [PW-1:0] r_holdQ;
  logic [CW-1:0] r_beatIdx;
  logic [CW-1:0] r_lastIdx;
  logic          r_error;

  logic          w_holdValid;
  logic          w_accept;
  logic          w_atLast;
  logic          w_done;
  logic          w_rdreq;
  logic [CW-1:0] w_count;
  logic          w_countErr;
  logic [CW-1:0] w_loadIdx;
  logic [PW-1:0] w_payload;

  // Split the FIFO head into payload and (optionally) the beats-1 field.
  // An oversized count is flagged and clamped to a full word.
  assign w_payload = in_q[PW-1:0];

  if (VAR_LEN != 0) begin : g_varLen
    assign w_count    = in_q[IN_WIDTH-1 -: CW];
    assign w_countErr = (w_count > MaxIdx);
  end else begin : g_fixedLen
    assign w_count    = MaxIdx;
    assign w_countErr = 1'b0;
  end

  assign w_loadIdx = w_countErr ? MaxIdx : w_count;

  // Handshake terms. A pop happens when nothing is held or when the last
  // beat of the held word leaves this cycle, giving bubble-free words.
  assign w_holdValid = (r_state == SEND);
  assign w_accept    = w_holdValid & out_ready;
  assign w_atLast    = (r_beatIdx == r_lastIdx);
  assign w_done      = w_accept & w_atLast;
  assign w_rdreq     = !rst & !in_empty & (!w_holdValid | w_done);

  assign in_rdreq  = w_rdreq;
  assign out_valid = w_holdValid;
  assign out_last  = w_holdValid & w_atLast;
  assign error_out = r_error;

  // Next state: a pop always (re)fills the holding stage; finishing a word
  // without a replacement returns to IDLE.
  always_comb begin
    w_nextState = r_state;
    if (w_rdreq) begin
      w_nextState = SEND;
    end else if (w_done) begin
      w_nextState = IDLE;
    end
  end

  // State register; reset drops any partially sent word.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Beat counters and the registered count-error pulse.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_beatIdx <= '0;
      r_lastIdx <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error <= w_rdreq & w_countErr;
      if (w_rdreq) begin
        r_beatIdx <= '0;
        r_lastIdx <= w_loadIdx;
      end else if (w_accept && !w_atLast) begin
        r_beatIdx <= r_beatIdx + 1'b1;
      end
    end
  end

  // Payload capture; contents are meaningless while IDLE so no reset is needed.
  always_ff @(posedge clock) begin
    if (w_rdreq) begin
      r_holdQ <= w_payload;
    end
  end

  // Select the current beat slice in the configured order.
  always_comb begin
    out_data = '0;
    for (int b = 0; b < RATIO; b++) begin
      if (r_beatIdx == CW'(b)) begin
        if (LSB_FIRST != 0) begin
          out_data = r_holdQ[b*OUT_WIDTH +: OUT_WIDTH];
        end else begin
          out_data = r_holdQ[(RATIO-1-b)*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_internal_fifo_word_unpacker.sv
// Testbench for internal_fifo_word_unpacker. Three configurations are
// instantiated (LSB-first fixed length, variable length RATIO=3, MSB-first);
// one is exercised at a time against a queue-based FIFO and beat scoreboard.
module tb_internal_fifo_word_unpacker;

  logic        clock = 1'b0;
  logic        rst;
  logic [2:0]  inEmpty;
  logic [2:0]  outReady;
  logic [31:0] inQA;
  logic [25:0] inQB;
  logic [31:0] inQC;
  wire  [2:0]  inRdreq;
  wire  [2:0]  outValid;
  wire  [2:0]  outLast;
  wire  [2:0]  errorOut;
  wire  [2:0][7:0] outData;

  int          checks = 0;
  int          errors = 0;
  int          sel    = 0;
  logic [31:0] fifo[$];
  logic [7:0]  sbData[$];
  logic        sbLast[$];
  logic        expErr = 1'b0;

  // Free-running clock.
  always #5 clock = ~clock;

  internal_fifo_word_unpacker #(.OUT_WIDTH(8), .RATIO(4), .VAR_LEN(0), .LSB_FIRST(1)) dutA (
    .clock(clock), .rst(rst), .in_empty(inEmpty[0]), .in_q(inQA), .in_rdreq(inRdreq[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .out_last(outLast[0]), .error_out(errorOut[0]));

  internal_fifo_word_unpacker #(.OUT_WIDTH(8), .RATIO(3), .VAR_LEN(1), .LSB_FIRST(1)) dutB (
    .clock(clock), .rst(rst), .in_empty(inEmpty[1]), .in_q(inQB), .in_rdreq(inRdreq[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .out_last(outLast[1]), .error_out(errorOut[1]));

  internal_fifo_word_unpacker #(.OUT_WIDTH(8), .RATIO(4), .VAR_LEN(0), .LSB_FIRST(0)) dutC (
    .clock(clock), .rst(rst), .in_empty(inEmpty[2]), .in_q(inQC), .in_rdreq(inRdreq[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
    .out_last(outLast[2]), .error_out(errorOut[2]));

  // Reference model: expand one popped word into its expected beats for the
  // selected configuration; returns whether a count error is expected.
  function automatic logic pushWord(input logic [31:0] w);
    int   n;
    logic err;
    err = 1'b0;
    n   = 4;
    if (sel == 1) begin
      n = int'(w[25:24]) + 1;
      if (n > 3) begin
        n   = 3;
        err = 1'b1;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (sel == 2) sbData.push_back(w[8*(3-i) +: 8]);
      else          sbData.push_back(w[8*i +: 8]);
      sbLast.push_back(i == n - 1);
    end
    return err;
  endfunction

  function automatic logic [31:0] randWord();
    if (sel == 1) return $urandom() & 32'h03FF_FFFF;
    return $urandom();
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, then
  // advance FIFO and scoreboard as the handshakes dictate.
  task automatic applyStimulus(input logic ready, input bit chk);
    logic [31:0] head;
    bit          expValid;
    bit          acc;
    bit          expRd;
    head = (fifo.size() != 0) ? fifo[0] : 32'h0;
    inEmpty       = 3'b111;
    outReady      = 3'b000;
    inEmpty[sel]  = (fifo.size() == 0);
    outReady[sel] = ready;
    inQA = head;
    inQB = head[25:0];
    inQC = head;
    #1;
    expValid = (sbData.size() != 0);
    acc      = expValid && ready;
    expRd    = !rst && (fifo.size() != 0) && (!expValid || (acc && sbData.size() == 1));
    if (chk) begin
      checks++;
      if (outValid[sel] !== expValid) begin
        errors++;
        $display("[TB] FAIL out_valid sel=%0d t=%0t: got %b, expected %b", sel, $time, outValid[sel], expValid);
      end
      checks++;
      if (inRdreq[sel] !== expRd) begin
        errors++;
        $display("[TB] FAIL in_rdreq sel=%0d t=%0t: got %b, expected %b", sel, $time, inRdreq[sel], expRd);
      end
      checks++;
      if (errorOut[sel] !== expErr) begin
        errors++;
        $display("[TB] FAIL error_out sel=%0d t=%0t: got %b, expected %b", sel, $time, errorOut[sel], expErr);
      end
      if (expValid) begin
        checks++;
        if (outData[sel] !== sbData[0]) begin
          errors++;
          $display("[TB] FAIL out_data sel=%0d t=%0t: got %h, expected %h", sel, $time, outData[sel], sbData[0]);
        end
        checks++;
        if (outLast[sel] !== sbLast[0]) begin
          errors++;
          $display("[TB] FAIL out_last sel=%0d t=%0t: got %b, expected %b", sel, $time, outLast[sel], sbLast[0]);
        end
      end
    end
    expErr = 1'b0;
    if (rst) begin
      sbData.delete();
      sbLast.delete();
    end else begin
      if (acc) begin
        void'(sbData.pop_front());
        void'(sbLast.pop_front());
      end
      if (inRdreq[sel] === 1'b1 && fifo.size() != 0) begin
        expErr = pushWord(fifo.pop_front());
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // Run with ready high until FIFO and scoreboard are empty, within a budget.
  task automatic drain();
    int n;
    n = 0;
    while ((fifo.size() != 0 || sbData.size() != 0) && n < 200) begin
      applyStimulus(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (fifo.size() != 0 || sbData.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain sel=%0d: fifo=%0d beats=%0d left, expected 0", sel, fifo.size(), sbData.size());
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    fifo.push_back(32'h0BAD_F00D);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    rst = 1'b0;
    drain();
  endtask

  task automatic test_basic();
    sel = 0;
    fifo.push_back(32'hDDCC_BBAA);
    applyStimulus(1'b1, 1'b1);
    checks++;
    if (outValid[0] !== 1'b1 || outData[0] !== 8'hAA || outLast[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_first_beat: got v=%b d=%h l=%b, expected v=1 d=aa l=0", outValid[0], outData[0], outLast[0]);
    end
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checks++;
    if (outData[0] !== 8'hDD || outLast[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_last_beat: got d=%h l=%b, expected d=dd l=1", outData[0], outLast[0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    sel = 0;
    fifo.push_back(randWord());
    fifo.push_back(randWord());
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b1);
    drain();
  endtask

  task automatic test_stall();
    sel = 0;
    for (int i = 0; i < 3; i++) fifo.push_back(randWord());
    for (int c = 0; c < 40; c++) applyStimulus((c % 4 == 0) || (c % 4 == 3), 1'b1);
    drain();
  endtask

  task automatic test_var_len();
    sel = 1;
    fifo.push_back(32'h0000_00A5);
    fifo.push_back(32'h03CC_BBAA);
    fifo.push_back(32'h0100_1234);
    fifo.push_back(32'h0256_7890);
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) fifo.push_back(randWord());
    for (int c = 0; c < 80; c++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);
    drain();
  endtask

  task automatic test_mid_reset();
    sel = 0;
    fifo.push_back(32'h4433_2211);
    fifo.push_back(32'h8877_6655);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if (outValid[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_valid: got %b, expected 0", outValid[0]);
    end
    drain();
  endtask

  task automatic test_msb_first();
    sel = 2;
    fifo.push_back(32'h1122_3344);
    applyStimulus(1'b1, 1'b1);
    checks++;
    if (outData[2] !== 8'h11) begin
      errors++;
      $display("[TB] FAIL msb_first_beat: got %h, expected 11", outData[2]);
    end
    drain();
  endtask

  task automatic test_soak();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 2) == 0 && fifo.size() < 4) fifo.push_back(randWord());
        applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      end
      drain();
    end
  endtask

  // Watchdog so a stuck run still ends with a failure line.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    rst      = 1'b1;
    inEmpty  = 3'b111;
    outReady = 3'b000;
    inQA     = '0;
    inQB     = '0;
    inQC     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_var_len();
    test_mid_reset();
    test_msb_first();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
